// File: rtl/parity_pkg.sv
// Shared parity-mode encodings and RX FSM state type for the parity engine.
package parity_pkg;

   localparam logic [2:0] PAR_NONE  = 3'b000;
   localparam logic [2:0] PAR_EVEN  = 3'b001;
   localparam logic [2:0] PAR_ODD   = 3'b010;
   localparam logic [2:0] PAR_MARK  = 3'b011;
   localparam logic [2:0] PAR_SPACE = 3'b100;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'b00,
      RX_DATA   = 2'b01,
      RX_PARITY = 2'b10
   } rx_state_e;

   // Codes 101..111 are reserved and behave exactly like none.
   function automatic logic par_active(input logic [2:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
             (mode == PAR_MARK) || (mode == PAR_SPACE);
   endfunction

endpackage

// File: rtl/parity_sel.sv
// Combinational parity generator: data vector plus mode to parity bit.
module parity_sel
   import parity_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] i_data,
   input  logic [2:0]   i_mode,
   output logic         o_par
);

   logic w_xor;

   always_comb begin
      w_xor = ^i_data;
      o_par = 1'b0;
      case (i_mode)
         PAR_EVEN: o_par = w_xor;
         PAR_ODD:  o_par = ~w_xor;
         PAR_MARK: o_par = 1'b1;
         default:  o_par = 1'b0;
      endcase
   end

endmodule

// File: rtl/parity_engine.sv
// UART-style parity engine: TX parity generation and RX parity check with
// a saturating error counter. The TX and RX paths share only the mode input.
module parity_engine
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [2:0]               PAR_MODE,
   input  logic [DATA_WIDTH-1:0]    P_DATA,
   input  logic                     Data_Valid,
   output logic                     par_bit,
   output logic                     par_en,
   input  logic                     rx_start,
   input  logic                     rx_bit_valid,
   input  logic                     rx_bit,
   output logic                     rx_done,
   output logic                     par_err,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   input  logic                     err_clr
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   // ---------------- TX path ----------------
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [2:0]            r_tx_mode;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_tx_data <= '0;
         r_tx_mode <= PAR_NONE;
      end else if (Data_Valid) begin
         r_tx_data <= P_DATA;
         r_tx_mode <= PAR_MODE;
      end
   end

   parity_sel #(.W(DATA_WIDTH)) u_tx_sel (
      .i_data (r_tx_data),
      .i_mode (r_tx_mode),
      .o_par  (par_bit)
   );

   assign par_en = par_active(r_tx_mode);

   // ---------------- RX path ----------------
   rx_state_e             r_state, w_state_nxt;
   logic                  r_acc, w_acc_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic [2:0]            r_rx_mode, w_rx_mode_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_err, w_err_nxt;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
   logic                  w_rx_exp;

   // Parity of the accumulated data equals parity of the single XOR bit.
   parity_sel #(.W(DATA_WIDTH)) u_rx_sel (
      .i_data ({{(DATA_WIDTH-1){1'b0}}, r_acc}),
      .i_mode (r_rx_mode),
      .o_par  (w_rx_exp)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_acc_nxt     = r_acc;
      w_cnt_nxt     = r_cnt;
      w_rx_mode_nxt = r_rx_mode;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      if (rx_start) begin
         // A new start always restarts; any frame in flight is dropped silently.
         w_state_nxt   = RX_DATA;
         w_acc_nxt     = 1'b0;
         w_cnt_nxt     = '0;
         w_rx_mode_nxt = PAR_MODE;
      end else begin
         case (r_state)
            RX_DATA: begin
               if (rx_bit_valid) begin
                  w_acc_nxt = r_acc ^ rx_bit;
                  w_cnt_nxt = r_cnt + 1'b1;
                  if (r_cnt == LAST_BIT) begin
                     if (par_active(r_rx_mode)) begin
                        w_state_nxt = RX_PARITY;
                     end else begin
                        w_state_nxt = RX_IDLE;
                        w_done_nxt  = 1'b1;
                     end
                  end
               end
            end
            RX_PARITY: begin
               if (rx_bit_valid) begin
                  w_state_nxt = RX_IDLE;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = (rx_bit != w_rx_exp);
               end
            end
            default: w_state_nxt = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= RX_IDLE;
         r_acc     <= 1'b0;
         r_cnt     <= '0;
         r_rx_mode <= PAR_NONE;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rx_mode <= w_rx_mode_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // Counter updates on the same edge that raises par_err; clear wins.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_err_cnt <= '0;
      end else if (err_clr) begin
         r_err_cnt <= '0;
      end else if (w_err_nxt && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign rx_done = r_done;
   assign par_err = r_err;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_parity_engine.sv
// Directed self-checking bench for parity_engine (default and 2-bit counter).
module tb_parity_engine;

   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] PAR_MODE;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       rx_start, rx_bit_valid, rx_bit, err_clr;
   logic       par_bit, par_en, rx_done, par_err;
   logic [7:0] err_cnt;
   logic       par_bit2, par_en2, rx_done2, par_err2;
   logic [1:0] err_cnt2;

   int n_chk  = 0;
   int n_fail = 0;
   int n_done = 0;
   int n_err  = 0;
   int base_done, base_err;

   always #5 CLK = ~CLK;

   parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) u_dut (
      .CLK(CLK), .RST(RST), .PAR_MODE(PAR_MODE), .P_DATA(P_DATA),
      .Data_Valid(Data_Valid), .par_bit(par_bit), .par_en(par_en),
      .rx_start(rx_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
      .rx_done(rx_done), .par_err(par_err), .err_cnt(err_cnt), .err_clr(err_clr)
   );

   parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_dut2 (
      .CLK(CLK), .RST(RST), .PAR_MODE(PAR_MODE), .P_DATA(P_DATA),
      .Data_Valid(Data_Valid), .par_bit(par_bit2), .par_en(par_en2),
      .rx_start(rx_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
      .rx_done(rx_done2), .par_err(par_err2), .err_cnt(err_cnt2), .err_clr(err_clr)
   );

   always @(posedge CLK) begin
      if (rx_done) n_done <= n_done + 1;
      if (par_err) n_err  <= n_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic tx_load(input logic [2:0] mode, input logic [7:0] data);
      PAR_MODE = mode; P_DATA = data; Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
   endtask

   // Sends start + 8 data bits (LSB first) and optionally the parity bit;
   // returns just after the last accepting edge.
   task automatic rx_frame(input logic [2:0] mode, input logic [7:0] data,
                           input logic pbit, input logic do_par,
                           input logic clr, input logic bv_on_start);
      PAR_MODE = mode; rx_start = 1'b1; rx_bit_valid = bv_on_start; rx_bit = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rx_bit_valid = 1'b1; rx_bit = data[i];
         tick();
      end
      rx_bit_valid = 1'b0;
      if (do_par) begin
         check("no_done_before_parity", {31'd0, rx_done}, 32'd0);
         rx_bit = pbit; rx_bit_valid = 1'b1; err_clr = clr;
         tick();
         rx_bit_valid = 1'b0; err_clr = 1'b0;
      end
   endtask

   task automatic do_reset();
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
   endtask

   initial begin
      PAR_MODE = 3'b000; P_DATA = 8'h00; Data_Valid = 1'b0;
      rx_start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0; err_clr = 1'b0;
      do_reset();
      check("rst_par_bit", {31'd0, par_bit}, 32'd0);
      check("rst_par_en",  {31'd0, par_en},  32'd0);
      check("rst_rx_done", {31'd0, rx_done}, 32'd0);
      check("rst_par_err", {31'd0, par_err}, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

      // TX: 0xA5 has four ones
      tx_load(3'b001, 8'hA5);
      check("tx_even_a5", {31'd0, par_bit}, 32'd0);
      check("tx_even_en", {31'd0, par_en},  32'd1);
      tx_load(3'b010, 8'hA5);
      check("tx_odd_a5",  {31'd0, par_bit}, 32'd1);
      tx_load(3'b011, 8'h00);
      check("tx_mark", {31'd0, par_bit}, 32'd1);
      PAR_MODE = 3'b100;
      tick(); tick();
      check("tx_mode_hold_bit", {31'd0, par_bit}, 32'd1);
      check("tx_mode_hold_en",  {31'd0, par_en},  32'd1);
      tx_load(3'b100, 8'hFF);
      check("tx_space", {31'd0, par_bit}, 32'd0);
      tx_load(3'b001, 8'h07);
      check("tx_even_07", {31'd0, par_bit}, 32'd1);
      tx_load(3'b000, 8'h07);
      check("tx_none_bit", {31'd0, par_bit}, 32'd0);
      check("tx_none_en",  {31'd0, par_en},  32'd0);
      tx_load(3'b111, 8'h07);
      check("tx_rsvd_en",  {31'd0, par_en},  32'd0);

      // RX odd 0x3C (four ones): expected parity 1
      rx_frame(3'b010, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      check("rx_odd_ok_done", {31'd0, rx_done}, 32'd1);
      check("rx_odd_ok_err",  {31'd0, par_err}, 32'd0);
      tick();
      check("rx_done_one_cycle", {31'd0, rx_done}, 32'd0);
      rx_frame(3'b010, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      check("rx_odd_bad_done", {31'd0, rx_done}, 32'd1);
      check("rx_odd_bad_err",  {31'd0, par_err}, 32'd1);
      check("rx_odd_bad_cnt",  {24'd0, err_cnt}, 32'd1);
      tick();
      check("rx_err_one_cycle", {31'd0, par_err}, 32'd0);

      // RX none: done right after the 8th strobe, no parity consumed
      rx_frame(3'b000, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rx_none_done", {31'd0, rx_done}, 32'd1);
      check("rx_none_err",  {31'd0, par_err}, 32'd0);
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      tick();
      rx_bit_valid = 1'b0;
      tick();
      check("rx_idle_ignore", {31'd0, rx_done}, 32'd0);

      // Discarded strobe on rx_start: even 0x00 expects parity 0
      rx_frame(3'b001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      check("rx_start_bv_done", {31'd0, rx_done}, 32'd1);
      check("rx_start_bv_err",  {31'd0, par_err}, 32'd0);
      tick(); tick();

      // Abort after 4 bits, then full even 0xFF frame with parity 0
      base_done = n_done; base_err = n_err;
      PAR_MODE = 3'b001; rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rx_bit_valid = 1'b1; rx_bit = 1'b1; tick();
      end
      rx_bit_valid = 1'b0;
      rx_frame(3'b001, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      check("abort_done_count", n_done - base_done, 32'd1);
      check("abort_err_count",  n_err - base_err,  32'd0);

      // Saturation on the 2-bit counter
      do_reset();
      check("rst2_err_cnt", {30'd0, err_cnt2}, 32'd0);
      for (int f = 0; f < 2; f++) begin
         rx_frame(3'b010, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      check("sat_cnt2_at2", {30'd0, err_cnt2}, 32'd2);
      for (int f = 0; f < 2; f++) begin
         rx_frame(3'b010, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      check("sat_cnt2_at4", {30'd0, err_cnt2}, 32'd3);
      check("sat_cnt8_at4", {24'd0, err_cnt},  32'd4);
      rx_frame(3'b010, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
      check("clr_wins_cnt2", {30'd0, err_cnt2}, 32'd0);
      check("clr_wins_err",  {31'd0, par_err2}, 32'd1);
      check("clr_wins_cnt8", {24'd0, err_cnt},  32'd0);
      tick(); tick();

      // Reset mid-frame: remaining strobes must not complete anything
      base_done = n_done; base_err = n_err;
      PAR_MODE = 3'b001; rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rx_bit_valid = 1'b1; rx_bit = 1'b1; tick();
      end
      rx_bit_valid = 1'b0;
      RST = 1'b0;
      #3;
      check("async_rst_cnt2", {30'd0, err_cnt2}, 32'd0);
      RST = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         rx_bit_valid = 1'b1; rx_bit = 1'b1; tick();
      end
      rx_bit_valid = 1'b0;
      tick(); tick();
      check("midrst_done_count", n_done - base_done, 32'd0);
      check("midrst_err_count",  n_err - base_err,  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound reached");
      $fatal(1);
   end

endmodule

// File: doc/parity_engine.md
PARITY_ENGINE -- requirements
Module: parity_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..16.
REQ-002 Parameter ERR_CNT_WIDTH, default 8: width of the saturating parity-error counter.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 PAR_MODE  input  3  parity mode: 000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); 101..111 behave as none.
REQ-006 P_DATA  input  DATA_WIDTH  TX parallel data word.
REQ-007 Data_Valid  input  1  TX load strobe, single-cycle.
REQ-008 par_bit  output  1  TX parity bit for the last loaded word.
REQ-009 par_en  output  1  high when the latched TX mode is not none.
REQ-010 rx_start  input  1  RX frame start; asserted once after start-bit detection.
REQ-011 rx_bit_valid  input  1  RX sample strobe that qualifies rx_bit.
REQ-012 rx_bit  input  1  sampled RX bit: data LSB first, then the parity bit.
REQ-013 rx_done  output  1  one-cycle pulse marking the end of the RX check.
REQ-014 par_err  output  1  one-cycle pulse coincident with rx_done on a parity mismatch.
REQ-015 err_cnt  output  ERR_CNT_WIDTH  saturating count of par_err pulses.
REQ-016 err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-017 TX path shall latch P_DATA and PAR_MODE together on the CLK edge where Data_Valid=1; otherwise it holds them.
REQ-018 par_bit shall be derived combinationally from the latched values, valid from the edge after Data_Valid: even = XOR of data, odd = XNOR, mark = 1, space = 0, none = 0.
REQ-019 A PAR_MODE change without Data_Valid shall not alter par_bit or par_en.
REQ-020 RX FSM states: IDLE, DATA, PARITY.
REQ-021 In any state, rx_start shall go to DATA, clear the XOR accumulator and bit counter, latch PAR_MODE into rx_mode, and take priority over a same-cycle rx_bit_valid, whose bit is discarded.
REQ-022 rx_start arriving in DATA or PARITY shall abort the current frame with no rx_done or par_err.
REQ-023 In DATA, each rx_bit_valid shall XOR rx_bit into the accumulator and increment the counter; the strobe carrying bit DATA_WIDTH-1 exits DATA.
REQ-024 Exit from DATA: with rx_mode none, the FSM goes to IDLE and pulses rx_done on the next cycle with par_err=0; otherwise it goes to PARITY.
REQ-025 In PARITY, rx_bit_valid shall compare rx_bit with the expected bit computed from the accumulator and rx_mode per REQ-018, then return to IDLE.
REQ-026 After the PARITY compare, rx_done shall pulse one cycle after the accepting edge; par_err pulses in the same cycle on a mismatch.
REQ-027 In IDLE, rx_bit_valid without rx_start shall be ignored.
REQ-028 err_cnt shall increment on each par_err and saturate at all-ones, with no wrap.
REQ-029 err_clr shall set err_cnt to 0 and win over a simultaneous increment; par_err still pulses.
REQ-030 The TX and RX paths shall be independent and may operate in the same cycle.

Reset
REQ-031 RST low shall asynchronously set: the FSM to IDLE; accumulator, counter, latched data and err_cnt to 0; latched TX and RX modes to none. par_bit, par_en, rx_done and par_err read 0.
REQ-032 Reset asserted mid-frame shall discard the frame and produce no rx_done or par_err after release.

Structure
REQ-033 Shared package parity_pkg shall hold the PAR_MODE encodings and the RX FSM state encoding.
REQ-034 One sub-module, parity_sel (data vector + mode -> parity bit, combinational), shall be instantiated once for TX and once for RX.

Verification
REQ-035 Load P_DATA=0xA5, PAR_MODE=even, Data_Valid -> par_bit=0, par_en=1; reload with PAR_MODE=odd -> par_bit=1.
REQ-036 Set PAR_MODE=mark, then change it to space without Data_Valid -> par_bit stays 1.
REQ-037 RX, odd mode, data 0x3C, parity bit 1 -> rx_done pulses 1 cycle after the parity strobe, par_err=0; same frame with parity bit 0 -> par_err=1, err_cnt+1.
REQ-038 RX, mode none, 8 data strobes -> rx_done after the 8th strobe, no parity strobe consumed, par_err=0.
REQ-039 rx_start after 4 data bits, then a full even frame 0xFF with parity bit 0 -> exactly one rx_done, par_err=0.
REQ-040 ERR_CNT_WIDTH=2: 4 erroring frames -> err_cnt=3; err_clr coincident with a 5th error -> err_cnt=0, par_err=1; RST mid-frame -> no pulses.
